// File: rtl/ahb_write_checker.sv
// ahb_write_checker: passive AHB-Lite write-beat checker predicting address/data and burst length.
// Optional first-error capture ports are enabled with WCHK_FIRST_ERR_CAPTURE_EN.
module ahb_write_checker #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 6,
    parameter int ADDR_STEP = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    input  logic [LEN_W-1:0]     cfg_words_n,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic                 cfg_addr_dir,
    input  logic                 cfg_data_mode,
    input  logic [DATA_W-1:0]    init_data,
    input  logic [ADDR_W-1:0]    mem_WR_addr,
    input  logic                 mem_write_flag,
    input  logic [DATA_W-1:0]    HWDATA_toMem,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 data_err,
    output logic                 addr_err,
    output logic                 len_err,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
    output logic                 first_err_valid,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [DATA_W-1:0]    first_err_exp,
    output logic [DATA_W-1:0]    first_err_act,
`endif
    output logic [LEN_W:0]       beat_count
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    state_t state;
    logic [LEN_W-1:0] words_n;
    logic dir, mode, mism;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic beat, d_bad, a_bad, bad, ovr, fin, len_hit, start;
    logic [LEN_W:0] cnt_nxt;
    logic [ERR_CNT_W+1:0] sum;
    logic [ERR_CNT_W-1:0] err_nxt;

    assign busy = state == CHECK;

    always_comb begin
        start   = state == IDLE && HTRANS != 2'b00;
        beat    = state == CHECK && mem_write_flag;
        d_bad   = beat && exp_data != HWDATA_toMem;
        a_bad   = beat && exp_addr != mem_WR_addr;
        bad     = d_bad | a_bad;
        cnt_nxt = beat_count + (LEN_W+1)'(beat);
        ovr     = beat && beat_count == {1'b0, words_n};
        fin     = state == CHECK && HREADY && HTRANS == 2'b00;
        // An overrun already accounts for the length error, so the end-of-transfer check is suppressed
        len_hit = !len_err && (ovr || (fin && cnt_nxt != {1'b0, words_n}));
        sum     = {2'b00, err_count} + (ERR_CNT_W+2)'(bad) + (ERR_CNT_W+2)'(len_hit);
        err_nxt = sum > {2'b00, {ERR_CNT_W{1'b1}}} ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= IDLE;
            words_n    <= '0;
            dir        <= 1'b0;
            mode       <= 1'b0;
            mism       <= 1'b0;
            exp_addr   <= '0;
            exp_data   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            data_err   <= 1'b0;
            addr_err   <= 1'b0;
            len_err    <= 1'b0;
            err_count  <= '0;
            beat_count <= '0;
        end else begin
            data_err  <= d_bad;
            addr_err  <= a_bad;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= err_nxt;
            case (state)
                IDLE: if (start) begin
                    state      <= CHECK;
                    words_n    <= cfg_words_n;
                    dir        <= cfg_addr_dir;
                    mode       <= cfg_data_mode;
                    exp_addr   <= cfg_base_addr;
                    exp_data   <= init_data;
                    beat_count <= '0;
                    len_err    <= 1'b0;
                    mism       <= 1'b0;
                end
                CHECK: begin
                    if (beat) begin
                        beat_count <= cnt_nxt;
                        exp_addr   <= dir ? exp_addr - ADDR_W'(ADDR_STEP) : exp_addr + ADDR_W'(ADDR_STEP);
                        exp_data   <= mode ? exp_data : exp_data + DATA_W'(1);
                        mism       <= mism | bad;
                    end
                    if (len_hit) len_err <= 1'b1;
                    if (fin) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= !(mism | bad | len_err | len_hit);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WCHK_FIRST_ERR_CAPTURE_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET || start) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
        end else if (bad && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= mem_WR_addr;
            first_err_exp   <= exp_data;
            first_err_act   <= HWDATA_toMem;
        end
    end
`endif
endmodule

// File: tb/tb_ahb_write_checker.sv
// tb_ahb_write_checker: directed checks of ahb_write_checker (ADDR_STEP=1 and ADDR_STEP=4 instances).
module tb_ahb_write_checker;
    logic HCLK, HRESET, HREADY, cfg_addr_dir, cfg_data_mode, mem_write_flag;
    logic [1:0] HTRANS;
    logic [5:0] cfg_words_n;
    logic [31:0] cfg_base_addr, init_data, mem_WR_addr, HWDATA_toMem;
    logic busy, done, pass, data_err, addr_err, len_err;
    logic [7:0] err_count;
    logic [6:0] beat_count;
    logic b_busy, b_done, b_pass, b_data_err, b_addr_err, b_len_err;
    logic [7:0] b_err_count;
    logic [6:0] b_beat_count;
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
    logic fe_valid, b_fe_valid;
    logic [31:0] fe_addr, fe_exp, fe_act, b_fe_addr, b_fe_exp, b_fe_act;
`endif
    int passed = 0;
    int total = 0;

    ahb_write_checker u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HREADY(HREADY),
        .cfg_words_n(cfg_words_n), .cfg_base_addr(cfg_base_addr), .cfg_addr_dir(cfg_addr_dir),
        .cfg_data_mode(cfg_data_mode), .init_data(init_data), .mem_WR_addr(mem_WR_addr),
        .mem_write_flag(mem_write_flag), .HWDATA_toMem(HWDATA_toMem), .busy(busy), .done(done),
        .pass(pass), .data_err(data_err), .addr_err(addr_err), .len_err(len_err),
        .err_count(err_count),
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
        .first_err_valid(fe_valid), .first_err_addr(fe_addr), .first_err_exp(fe_exp),
        .first_err_act(fe_act),
`endif
        .beat_count(beat_count)
    );

    ahb_write_checker #(.ADDR_STEP(4)) u4 (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HREADY(HREADY),
        .cfg_words_n(cfg_words_n), .cfg_base_addr(cfg_base_addr), .cfg_addr_dir(cfg_addr_dir),
        .cfg_data_mode(cfg_data_mode), .init_data(init_data), .mem_WR_addr(mem_WR_addr),
        .mem_write_flag(mem_write_flag), .HWDATA_toMem(HWDATA_toMem), .busy(b_busy), .done(b_done),
        .pass(b_pass), .data_err(b_data_err), .addr_err(b_addr_err), .len_err(b_len_err),
        .err_count(b_err_count),
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
        .first_err_valid(b_fe_valid), .first_err_addr(b_fe_addr), .first_err_exp(b_fe_exp),
        .first_err_act(b_fe_act),
`endif
        .beat_count(b_beat_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc(input logic [1:0] t, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        HTRANS = t; HREADY = r; mem_write_flag = w; mem_WR_addr = a; HWDATA_toMem = d;
        @(posedge HCLK); #1;
    endtask

    task automatic set_cfg(input logic [5:0] n, input logic [31:0] base, input logic dir, input logic [31:0] init, input logic mode);
        cfg_words_n = n; cfg_base_addr = base; cfg_addr_dir = dir; init_data = init; cfg_data_mode = mode;
    endtask

    task automatic rst_dut();
        HRESET = 1'b1;
        cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        HRESET = 1'b0;
    endtask

    // Step-1 transfer; cfg is scrambled after the start cycle since it must be sampled only at start
    task automatic xfer(input logic [5:0] n, input int beats, input logic [31:0] base, input logic dir, input logic [31:0] init, input logic mode);
        set_cfg(n, base, dir, init, mode);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        set_cfg(6'd9, 32'h5555, ~dir, 32'h77, ~mode);
        for (int i = 0; i < beats; i++)
            cyc(i == beats - 1 ? 2'b00 : 2'b11, 1'b1, 1'b1, dir ? base - i : base + i, mode ? init : init + i);
        if (beats == 0) cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_dut();
        total++; if ({busy, done, pass, data_err, addr_err, len_err} !== 6'b0) $display("FAIL reset flags: got %b want 000000", {busy, done, pass, data_err, addr_err, len_err}); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset err_count: got %0d want 0", err_count); else passed++;
        total++; if (beat_count !== 7'd0) $display("FAIL reset beat_count: got %0d want 0", beat_count); else passed++;
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
        total++; if ({fe_valid, fe_addr, fe_exp, fe_act} !== 97'b0) $display("FAIL reset first_err: got %h want 0", {fe_valid, fe_addr, fe_exp, fe_act}); else passed++;
`endif
    endtask

    task automatic test_basic();
        rst_dut();
        xfer(6'd4, 4, 32'h100, 1'b1, 32'hA5, 1'b0);
        total++; if (done !== 1'b1) $display("FAIL basic done: got %b want 1", done); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL basic pass: got %b want 1", pass); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL basic err_count: got %0d want 0", err_count); else passed++;
        total++; if (beat_count !== 7'd4) $display("FAIL basic beat_count: got %0d want 4", beat_count); else passed++;
        total++; if (len_err !== 1'b0) $display("FAIL basic len_err: got %b want 0", len_err); else passed++;
        cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        total++; if ({done, busy, pass} !== 3'b000) $display("FAIL basic after done: got %b want 000", {done, busy, pass}); else passed++;
    endtask

    task automatic test_data_err();
        rst_dut();
        set_cfg(6'd4, 32'h100, 1'b1, 32'hA5, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        total++; if (busy !== 1'b1) $display("FAIL derr busy: got %b want 1", busy); else passed++;
        cyc(2'b11, 1'b1, 1'b1, 32'h100, 32'hA5);
        cyc(2'b11, 1'b1, 1'b1, 32'hFF, 32'hA6);
        total++; if (data_err !== 1'b0) $display("FAIL derr early: got %b want 0", data_err); else passed++;
        cyc(2'b11, 1'b1, 1'b1, 32'hFE, 32'hFF);
        total++; if ({data_err, addr_err} !== 2'b10) $display("FAIL derr pulse: got %b want 10", {data_err, addr_err}); else passed++;
`ifdef WCHK_FIRST_ERR_CAPTURE_EN
        total++; if ({fe_valid, fe_addr, fe_exp, fe_act} !== {1'b1, 32'hFE, 32'hA7, 32'hFF}) $display("FAIL derr first_err: got %h want %h", {fe_valid, fe_addr, fe_exp, fe_act}, {1'b1, 32'hFE, 32'hA7, 32'hFF}); else passed++;
`endif
        cyc(2'b00, 1'b1, 1'b1, 32'hFD, 32'hA8);
        total++; if (data_err !== 1'b0) $display("FAIL derr one-cycle: got %b want 0", data_err); else passed++;
        total++; if ({done, pass} !== 2'b10) $display("FAIL derr done/pass: got %b want 10", {done, pass}); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL derr err_count: got %0d want 1", err_count); else passed++;
    endtask

    task automatic test_len();
        rst_dut();
        xfer(6'd4, 3, 32'h100, 1'b1, 32'hA5, 1'b0);
        total++; if ({done, pass, len_err} !== 3'b101) $display("FAIL short done/pass/len: got %b want 101", {done, pass, len_err}); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL short err_count: got %0d want 1", err_count); else passed++;
        rst_dut();
        set_cfg(6'd4, 32'h100, 1'b1, 32'hA5, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) cyc(2'b11, 1'b1, 1'b1, 32'h100 - i, 32'hA5 + i);
        total++; if (len_err !== 1'b0) $display("FAIL ovr before 5th: got %b want 0", len_err); else passed++;
        cyc(2'b11, 1'b1, 1'b1, 32'hFC, 32'hA9);
        total++; if ({len_err, data_err, addr_err} !== 3'b100) $display("FAIL ovr 5th beat: got %b want 100", {len_err, data_err, addr_err}); else passed++;
        cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        total++; if ({done, pass} !== 2'b10) $display("FAIL ovr done/pass: got %b want 10", {done, pass}); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL ovr err_count: got %0d want 1", err_count); else passed++;
        total++; if (beat_count !== 7'd5) $display("FAIL ovr beat_count: got %0d want 5", beat_count); else passed++;
        rst_dut();
        xfer(6'd0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        total++; if ({done, pass, len_err} !== 3'b110) $display("FAIL n0 done/pass/len: got %b want 110", {done, pass, len_err}); else passed++;
    endtask

    task automatic test_wrap();
        rst_dut();
        set_cfg(6'd2, 32'hFFFFFFFC, 1'b0, 32'h55, 1'b1);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        cyc(2'b11, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h55);
        total++; if ({b_addr_err, b_data_err} !== 2'b00) $display("FAIL wrap beat1 errs: got %b want 00", {b_addr_err, b_data_err}); else passed++;
        cyc(2'b00, 1'b1, 1'b1, 32'h00000000, 32'h55);
        total++; if ({b_addr_err, b_data_err} !== 2'b00) $display("FAIL wrap beat2 errs: got %b want 00", {b_addr_err, b_data_err}); else passed++;
        total++; if ({b_done, b_pass} !== 2'b11) $display("FAIL wrap done/pass: got %b want 11", {b_done, b_pass}); else passed++;
        total++; if ({b_err_count, b_beat_count} !== {8'd0, 7'd2}) $display("FAIL wrap counts: got %0d/%0d want 0/2", b_err_count, b_beat_count); else passed++;
    endtask

    task automatic test_stall();
        rst_dut();
        set_cfg(6'd4, 32'h100, 1'b1, 32'hA5, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(2'b11, 1'b1, 1'b1, 32'h100 - i, 32'hA5 + i);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
            total++; if ({done, busy} !== 2'b01) $display("FAIL stall cycle %0d: got %b want 01", i, {done, busy}); else passed++;
        end
        total++; if (beat_count !== 7'd3) $display("FAIL stall beat_count: got %0d want 3", beat_count); else passed++;
        cyc(2'b00, 1'b1, 1'b1, 32'hFD, 32'hA8);
        total++; if ({done, pass} !== 2'b11) $display("FAIL stall done/pass: got %b want 11", {done, pass}); else passed++;
    endtask

    task automatic test_mid_reset();
        int pulses;
        rst_dut();
        set_cfg(6'd4, 32'h100, 1'b1, 32'hA5, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        cyc(2'b11, 1'b1, 1'b1, 32'h100, 32'h00);
        total++; if ({data_err, err_count} !== {1'b1, 8'd1}) $display("FAIL mrst pre: got %b/%0d want 1/1", data_err, err_count); else passed++;
        #2 HRESET = 1'b1;
        #1;
        total++; if ({busy, done, pass, data_err, addr_err, len_err, err_count, beat_count} !== 21'b0) $display("FAIL mrst async clear: got %h want 0", {busy, done, pass, data_err, addr_err, len_err, err_count, beat_count}); else passed++;
        cyc(2'b00, 1'b1, 1'b1, 32'hFF, 32'hA6);
        HRESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
            pulses += int'(done);
        end
        total++; if (pulses !== 0 || busy !== 1'b0) $display("FAIL mrst no done: got %0d pulses busy %b want 0 pulses busy 0", pulses, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        rst_dut();
        xfer(6'd4, 3, 32'h100, 1'b1, 32'hA5, 1'b0);
        total++; if ({done, len_err, err_count} !== {2'b11, 8'd1}) $display("FAIL b2b first: got %b/%b/%0d want 1/1/1", done, len_err, err_count); else passed++;
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        total++; if ({done, busy} !== 2'b00) $display("FAIL b2b idle gap: got %b want 00", {done, busy}); else passed++;
        xfer(6'd2, 2, 32'h40, 1'b0, 32'h11, 1'b1);
        total++; if ({done, pass, len_err} !== 3'b110) $display("FAIL b2b second: got %b want 110", {done, pass, len_err}); else passed++;
        total++; if ({err_count, beat_count} !== {8'd1, 7'd2}) $display("FAIL b2b persist: got %0d/%0d want 1/2", err_count, beat_count); else passed++;
    endtask

    task automatic test_saturate();
        rst_dut();
        set_cfg(6'd63, 32'h100, 1'b0, 32'hA5, 1'b1);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 300; i++) begin
            cyc(2'b11, 1'b1, 1'b1, 32'h0, 32'h0);
            if (i == 63) begin
                total++; if ({len_err, err_count} !== {1'b0, 8'd63}) $display("FAIL sat at 63: got %b/%0d want 0/63", len_err, err_count); else passed++;
            end
            if (i == 64) begin
                total++; if ({len_err, err_count} !== {1'b1, 8'd65}) $display("FAIL sat overrun: got %b/%0d want 1/65", len_err, err_count); else passed++;
            end
            if (i == 253) begin
                total++; if (err_count !== 8'd254) $display("FAIL sat at 253: got %0d want 254", err_count); else passed++;
            end
        end
        total++; if (err_count !== 8'd255) $display("FAIL sat hold: got %0d want 255", err_count); else passed++;
        cyc(2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        total++; if ({done, pass, err_count} !== {2'b10, 8'd255}) $display("FAIL sat end: got %b/%b/%0d want 1/0/255", done, pass, err_count); else passed++;
    endtask

    initial begin
        HRESET = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; mem_write_flag = 1'b0;
        mem_WR_addr = '0; HWDATA_toMem = '0;
        set_cfg(6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        test_reset();
        test_basic();
        test_data_err();
        test_len();
        test_wrap();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
